cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Sequencing controller for the 8-bit accumulator CPU. It sits on the far side of the ALU opcode/zero interface.
- It steps an 8-phase instruction cycle and decodes the 3-bit opcode from the instruction register. It consumes the ALU zero flag for skip-on-zero, and drives every datapath load, select, read and write strobe.
- Opcode encoding is shared with the ALU.

Parameters:
- OPC_W, 3, opcode width; fixed by the ISA, not intended to change.
- PHASE_W, 3, phase counter width; gives 8 phases.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  OPC_W  instruction-register opcode field; stable from phase 3 onward
- zero  in  1  ALU accumulator-is-zero flag (a_is_zero)
- sel  out  1  memory address mux: 1 = PC, 0 = IR operand
- rd  out  1  memory read enable
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment program counter
- ld_pc  out  1  load program counter from operand (jump)
- ld_ac  out  1  load accumulator from ALU output
- wr  out  1  memory write strobe
- data_e  out  1  drive accumulator onto data bus
- halt  out  1  processor halted
- phase  out  PHASE_W  current phase (debug/verification)

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- State:
  - phase register, 0..7, increments by 1 each clock and wraps 7->0.
  - halted flag.
- Reset (rst_n low, asynchronous, any time including mid-instruction):
  - phase=0, halted=0.
  - All strobe outputs read 0 while reset is held, except that sel follows the phase-0 decode (sel=1).
  - First active edge after release advances to phase 1.
- Outputs are decoded combinationally from the phase register, opcode and zero. There is no extra latency; a strobe is valid for the whole phase it belongs to.
- Per phase:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1, except when opcode=HLT. For HLT: halt=1, inc_pc=0, and halted is set at this edge.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- All unlisted outputs are 0 in each phase.
- Halt:
  - Once halted=1, phase freezes at 4 and halt stays 1.
  - All other strobes are forced to 0.
  - Only rst_n clears the halted state.
- SKZ: zero is sampled combinationally during phase 6 only. A change of zero in other phases has no effect.
- wr and ld_pc are never asserted in phases 0-5.
- wr and ld_ac are never asserted simultaneously.
- opcode changes during phases 0-2 must not affect outputs, because no opcode-dependent decode exists in those phases.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (HLT..JMP), reused by the ALU.
  - phase constants (INST_ADDR..STORE).
  - OPC_W and PHASE_W.
- No sub-module is needed. The phase counter and halted flag are in one sequential process; the output decode is one combinational process.

Test Plan:
- Reset/free-run: assert rst_n=0 mid-phase 5 -> phase=0 immediately and all strobes 0 except sel=1. Release -> phase runs 1..7, 0 on successive edges.
- ADD (opcode=2): phases 0-7 -> sel=1 in 0-3; rd=1 in 1,2,3,5,6,7; ld_ir=1 in 2,3; inc_pc=1 in 4; ld_ac=1 in 7 only; wr=0 throughout.
- SKZ (opcode=1): zero=1 -> inc_pc=1 in phases 4 and 6. Repeat with zero=0 -> inc_pc=1 in phase 4 only. Toggle zero in phase 5 -> no output effect.
- STO (opcode=6): data_e=1 in phases 6,7; wr=1 in phase 7 only; rd=0 in 5-7; ld_ac=0.
- JMP (opcode=7): ld_pc=1 in phases 6,7; inc_pc=1 in 4 only; rd=0 and ld_ac=0 in 5-7.
- HLT (opcode=0): halt=1 from phase 4. Phase stays 4 for 20 clocks with all other strobes 0 and inc_pc=0. Pulse rst_n low -> phase=0, halt=0, normal cycling resumes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: ISA opcodes, instruction-cycle
// phases and the widths both are carried on.
package cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int PHASE_W = 3;

    typedef enum logic [OPC_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Instructions that read a memory operand and write the result into the accumulator.
    function automatic logic is_aluop(input opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Sequencing controller: an 8-phase instruction cycle with a sticky halt, and
// datapath strobes decoded combinationally from the current phase and opcode.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    phase_e             phase_q, phase_d;
    logic               halted_q, halted_d;
    logic [PHASE_W-1:0] phase_inc;
    opcode_e            op;
    logic               alu_op;

    assign op        = opcode_e'(opcode);
    assign alu_op    = is_aluop(op);
    assign phase_inc = phase_q + 3'd1;
    assign phase     = phase_q;

    // A HLT in OP_ADDR latches halted and parks the counter there until reset.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && op == HLT) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_inc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    if (op == HLT) begin
                        halt = 1'b1;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                // zero only matters here: SKZ skips the next word by bumping the PC again.
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (op == SKZ) && zero;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (op == JMP);
                    wr     = (op == STO);
                    data_e = (op == STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
